// File: rtl/fifo_tg_pkg.sv
// ============================================================================
// fifo_tg_pkg : shared types and constants for the FIFO traffic generators
// Rev 1.0
// ============================================================================
`default_nettype none

package fifo_tg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam logic MODE_INC  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    localparam logic [7:0] DEFAULT_LFSR_TAPS = 8'hB8;

endpackage

`default_nettype wire

// File: rtl/fifo_pattern_gen.sv
// ============================================================================
// fifo_pattern_gen : next-word function for incrementing / Galois LFSR data
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_pattern_gen
    import fifo_tg_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(DEFAULT_LFSR_TAPS)
) (
    input  logic              mode,
    input  logic [DATA_W-1:0] cur,
    output logic [DATA_W-1:0] nxt
);

    always_comb begin
        nxt = cur + DATA_W'(1);
        case (mode)
            MODE_INC:  nxt = cur + DATA_W'(1);
            default:   nxt = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fifo_burst_writer.sv
// ============================================================================
// fifo_burst_writer : pushes a descriptor-defined pattern burst into a FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_burst_writer
    import fifo_tg_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                LEN_W     = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(DEFAULT_LFSR_TAPS),
    parameter int                STALL_W   = 16
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DATA_W-1:0]  cmd_seed,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               cmd_mode,
    input  logic               abort,
    output logic               wreq,
    output logic [DATA_W-1:0]  wdata,
    input  logic               wfull,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [LEN_W-1:0]   words_sent,
    output logic [STALL_W-1:0] stall_cnt
);

    state_t              state;
    state_t              state_nxt;
    logic                wreq_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic                ready_nxt;

    logic                mode;
    logic [LEN_W-1:0]    remaining;
    logic [DATA_W-1:0]   seed_eff;
    logic [DATA_W-1:0]   word_nxt;
    logic                start;
    logic                accept;
    logic                stalled;

    assign start   = (state == IDLE) && cmd_valid;
    assign accept  = (state == BURST) && !wfull;
    assign stalled = (state == BURST) && wfull;

    // An all-zero LFSR state would lock up, so a zero seed starts at 1.
    assign seed_eff = ((cmd_mode == MODE_LFSR) && (cmd_seed == '0)) ? DATA_W'(1) : cmd_seed;

    fifo_pattern_gen #(
        .DATA_W    (DATA_W),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_pattern_gen (
        .mode (mode),
        .cur  (wdata),
        .nxt  (word_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = (cmd_len == '0) ? FIN : BURST;
                end
            end
            BURST: begin
                if (abort || (accept && (remaining == LEN_W'(1)))) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Status outputs are registered from the next state, keeping wfull off any output path.
        wreq_nxt  = (state_nxt == BURST);
        busy_nxt  = (state_nxt == BURST);
        done_nxt  = (state_nxt == FIN);
        ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= IDLE;
            wreq      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            wreq      <= wreq_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            cmd_ready <= ready_nxt;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            mode       <= MODE_INC;
            wdata      <= '0;
            remaining  <= '0;
            words_sent <= '0;
            stall_cnt  <= '0;
            aborted    <= 1'b0;
        end else if (start) begin
            mode       <= cmd_mode;
            wdata      <= seed_eff;
            remaining  <= cmd_len;
            words_sent <= '0;
            stall_cnt  <= '0;
            aborted    <= 1'b0;
        end else begin
            if (accept) begin
                wdata      <= word_nxt;
                remaining  <= remaining - LEN_W'(1);
                words_sent <= words_sent + LEN_W'(1);
            end
            if (stalled && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
            if ((state == BURST) && abort) begin
                aborted <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_writer.sv
// ============================================================================
// tb_fifo_burst_writer : directed table plus randomized bursts vs cycle model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_burst_writer;

    localparam int MAXC = 600;

    logic        wclk = 1'b0;
    logic        wrst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_seed = 8'h00;
    logic [7:0]  cmd_len = 8'h00;
    logic        cmd_mode = 1'b0;
    logic        abort = 1'b0;
    logic        wreq;
    logic [7:0]  wdata;
    logic        wfull = 1'b0;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  words_sent;
    logic [15:0] stall_cnt;

    always #5 wclk = ~wclk;

    fifo_burst_writer #(
        .DATA_W    (8),
        .LEN_W     (8),
        .LFSR_TAPS (8'hB8),
        .STALL_W   (16)
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_seed   (cmd_seed),
        .cmd_len    (cmd_len),
        .cmd_mode   (cmd_mode),
        .abort      (abort),
        .wreq       (wreq),
        .wdata      (wdata),
        .wfull      (wfull),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .words_sent (words_sent),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic [7:0]      seed;
        logic [7:0]      len;
        logic            mode;
        int              st_from;
        int              st_num;
        int              ab_cyc;
        bit              ab_cmd;
        int              exp_ws;
        int              exp_stall;
        bit              exp_ab;
        int              nchk;
        logic [0:3][7:0] exp_w;
    } vec_t;

    vec_t       tbl [9];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         stall_plan [0:MAXC];
    int         abort_cyc;
    logic [7:0] got [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Word i of a burst, straight from the pattern definitions.
    function automatic logic [7:0] word_at(input logic [7:0] seed, input logic mode, input int i);
        logic [7:0] v;
        if (!mode) return seed + 8'(i);
        v = (seed == 8'h00) ? 8'h01 : seed;
        for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
        return v;
    endfunction

    // Entered and left at posedge+1. Phases: 0 burst, 1 done cycle, 2 back in idle.
    task automatic run_burst(input logic [7:0] seed, input logic [7:0] len,
                             input logic mode, input bit abort_with_cmd);
        int acc, stalls, phase;
        bit exp_ab;
        cmd_seed  = seed;
        cmd_len   = len;
        cmd_mode  = mode;
        cmd_valid = 1'b1;
        abort     = abort_with_cmd;
        wfull     = stall_plan[0];
        @(negedge wclk);
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge wclk); #1;
        cmd_valid = 1'b0;
        cmd_seed  = 8'($urandom);
        cmd_len   = 8'($urandom);
        got.delete();
        acc = 0; stalls = 0; exp_ab = 1'b0;
        phase = (len == 8'd0) ? 1 : 0;
        for (int c = 1; c <= MAXC; c++) begin
            wfull = stall_plan[c];
            abort = (phase == 0) ? (c == abort_cyc) : 1'($urandom_range(0, 1));
            @(negedge wclk);
            check("wreq", wreq, (phase == 0));
            check("busy", busy, (phase == 0));
            check("done", done, (phase == 1));
            check("cmd_ready", cmd_ready, (phase == 2));
            if (phase == 0) check("wdata", wdata, word_at(seed, mode, acc));
            if (phase == 2) break;
            if (phase == 0) begin
                if (!wfull) begin
                    got.push_back(wdata);
                    acc++;
                end else begin
                    stalls++;
                end
                if (abort) exp_ab = 1'b1;
                if (abort || acc == int'(len)) phase = 1;
            end else begin
                phase = 2;
            end
            @(posedge wclk); #1;
        end
        if (phase != 2) check("burst_timeout", phase, 2);
        check("words_sent", words_sent, acc);
        check("stall_cnt", stall_cnt, stalls);
        check("aborted", aborted, exp_ab);
        abort = 1'b0;
        wfull = 1'b0;
        @(posedge wclk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h10, 8'd4,  1'b0, 0, 0, -1, 1'b0, 4, 0, 1'b0, 4, {8'h10, 8'h11, 8'h12, 8'h13}};
        tbl[1] = '{8'hFE, 8'd3,  1'b0, 0, 0, -1, 1'b0, 3, 0, 1'b0, 3, {8'hFE, 8'hFF, 8'h00, 8'h00}};
        tbl[2] = '{8'h01, 8'd4,  1'b1, 0, 0, -1, 1'b0, 4, 0, 1'b0, 4, {8'h01, 8'hB8, 8'h5C, 8'h2E}};
        tbl[3] = '{8'h00, 8'd2,  1'b1, 0, 0, -1, 1'b0, 2, 0, 1'b0, 2, {8'h01, 8'hB8, 8'h00, 8'h00}};
        tbl[4] = '{8'h00, 8'd4,  1'b0, 3, 3, -1, 1'b0, 4, 3, 1'b0, 4, {8'h00, 8'h01, 8'h02, 8'h03}};
        tbl[5] = '{8'h20, 8'd10, 1'b0, 0, 0,  3, 1'b0, 3, 0, 1'b1, 3, {8'h20, 8'h21, 8'h22, 8'h00}};
        tbl[6] = '{8'h55, 8'd0,  1'b0, 0, 0, -1, 1'b0, 0, 0, 1'b0, 0, {8'h00, 8'h00, 8'h00, 8'h00}};
        tbl[7] = '{8'h40, 8'd5,  1'b0, 2, 2,  3, 1'b0, 1, 2, 1'b1, 1, {8'h40, 8'h00, 8'h00, 8'h00}};
        tbl[8] = '{8'h80, 8'd2,  1'b0, 0, 0, -1, 1'b1, 2, 0, 1'b0, 2, {8'h80, 8'h81, 8'h00, 8'h00}};

        repeat (2) @(posedge wclk);
        #1;
        check("rst_wreq", wreq, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wdata", wdata, 0);
        check("rst_words_sent", words_sent, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_aborted", aborted, 0);
        wrst_n = 1'b1;
        @(negedge wclk);
        check("rst_cmd_ready", cmd_ready, 1);
        @(posedge wclk); #1;

        for (int i = 0; i < 9; i++) begin
            for (int c = 0; c <= MAXC; c++) stall_plan[c] = 1'b0;
            for (int c = tbl[i].st_from; c < tbl[i].st_from + tbl[i].st_num; c++) stall_plan[c] = 1'b1;
            abort_cyc = tbl[i].ab_cyc;
            run_burst(tbl[i].seed, tbl[i].len, tbl[i].mode, tbl[i].ab_cmd);
            check("vec_words_sent", words_sent, tbl[i].exp_ws);
            check("vec_stall_cnt", stall_cnt, tbl[i].exp_stall);
            check("vec_aborted", aborted, tbl[i].exp_ab);
            check("vec_accepted", got.size(), tbl[i].exp_ws);
            for (int k = 0; k < tbl[i].nchk && k < got.size(); k++)
                check("vec_word", got[k], tbl[i].exp_w[k]);
        end

        // Reset in the middle of a burst: outputs drop at once, no done pulse.
        cmd_seed = 8'h33; cmd_len = 8'd10; cmd_mode = 1'b0; cmd_valid = 1'b1;
        @(posedge wclk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge wclk);
        #1;
        @(negedge wclk);
        check("mid_wreq_before", wreq, 1);
        #2 wrst_n = 1'b0;
        #1;
        check("mid_rst_wreq", wreq, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_wdata", wdata, 0);
        check("mid_rst_words_sent", words_sent, 0);
        check("mid_rst_stall_cnt", stall_cnt, 0);
        @(posedge wclk); #1;
        wrst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge wclk);
            check("post_rst_done", done, 0);
            check("post_rst_wreq", wreq, 0);
            check("post_rst_cmd_ready", cmd_ready, 1);
            @(posedge wclk); #1;
        end

        for (int r = 0; r < 30; r++) begin
            logic [7:0] seed;
            logic [7:0] len;
            logic       mode;
            seed = 8'($urandom);
            len  = 8'($urandom_range(0, 40));
            mode = 1'($urandom_range(0, 1));
            for (int c = 0; c <= MAXC; c++) stall_plan[c] = ($urandom_range(0, 9) < 3);
            abort_cyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(len) + 4)) : -1;
            run_burst(seed, len, mode, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
